// File: rtl/trng_pkg.sv
// Shared types and default parameters for the ring-oscillator TRNG post-processor.
package trng_pkg;

  // Von Neumann pair tracker: waiting for the first bit of a pair, or for the second.
  typedef enum logic {
    PAIR_A = 1'b0,
    PAIR_B = 1'b1
  } pair_state_t;

  localparam int unsigned DEF_WIDTH    = 32;
  localparam int unsigned DEF_DIV      = 4;
  localparam int unsigned DEF_RC_LIMIT = 16;

endpackage

// File: rtl/vn_debias.sv
// Von Neumann corrector: consumes strobed raw samples in pairs and emits one
// unbiased bit for every unequal pair (10 -> 1, 01 -> 0).
module vn_debias
  import trng_pkg::*;
(
  input  logic clk,
  input  logic clear,
  input  logic enable,
  input  logic strobe,
  input  logic sample,
  output logic bit_valid,
  output logic bit_out
);

  pair_state_t state_q, state_d;
  logic        a_q, a_d;

  // Pair state and stored first bit.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= PAIR_A;
      a_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
    end
  end

  // Next pair state; pausing discards a half-collected pair.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    bit_valid = 1'b0;
    bit_out   = a_q;
    if (!enable) begin
      state_d = PAIR_A;
    end else if (strobe) begin
      case (state_q)
        PAIR_A: begin
          a_d     = sample;
          state_d = PAIR_B;
        end
        PAIR_B: begin
          bit_valid = (a_q != sample);
          state_d   = PAIR_A;
        end
        default: state_d = PAIR_A;
      endcase
    end
  end

endmodule

// File: rtl/ro_trng_postproc.sv
// Post-processing behind the ring-oscillator XOR tree: sample divider,
// repetition-count health test, von Neumann debias and word packer with a
// valid/ready output.
//
// Handshake: out_data/out_valid come straight from registers. A word is taken
// by the consumer at a posedge where out_valid & out_ready are both 1; while
// out_valid=1 and out_ready=0 the word is held unchanged. A completed word is
// loaded whenever the output register is empty or being taken in that same
// edge, so words can move back-to-back. A health failure drops out_valid and
// stops all further transfers until clear.
module ro_trng_postproc
  import trng_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned DIV      = DEF_DIV,
  parameter int unsigned RC_LIMIT = DEF_RC_LIMIT
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic             raw_bit,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             health_fail
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RW = $clog2(RC_LIMIT + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [RW-1:0] RC_MAX   = RW'(RC_LIMIT);
  localparam logic [BW-1:0] BIT_FULL = BW'(WIDTH);

  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic             strobe;
  logic [RW-1:0]    rc_cnt_q, rc_cnt_d;
  logic             prev_q, prev_d;
  logic             fail_q, fail_d;
  logic             bit_valid, bit_out;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             complete, xfer;

  // Sample divider: strobe on the last count of each DIV-cycle window.
  always_comb begin
    strobe    = enable && (div_cnt_q == DIV_LAST);
    div_cnt_d = div_cnt_q;
    if (!enable || strobe) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + DW'(1);
    end
  end

  // Repetition-count test on every strobed sample; rc_cnt==0 marks "no sample yet".
  always_comb begin
    rc_cnt_d = rc_cnt_q;
    prev_d   = prev_q;
    fail_d   = fail_q;
    if (strobe) begin
      prev_d = raw_bit;
      if ((rc_cnt_q == '0) || (raw_bit != prev_q)) begin
        rc_cnt_d = RW'(1);
      end else if (rc_cnt_q != RC_MAX) begin
        rc_cnt_d = rc_cnt_q + RW'(1);
      end
      if (rc_cnt_d == RC_MAX) begin
        fail_d = 1'b1;
      end
    end
  end

  vn_debias u_vn_debias (
    .clk       (clk),
    .clear     (clear),
    .enable    (enable),
    .strobe    (strobe),
    .sample    (raw_bit),
    .bit_valid (bit_valid),
    .bit_out   (bit_out)
  );

  assign complete = (bit_cnt_q == BIT_FULL);
  assign xfer     = complete && !fail_q && (!valid_q || out_ready);

  // Packer and output register; bits arriving on a full, untransferred word are dropped.
  always_comb begin
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    if (xfer) begin
      data_d    = sh_q;
      valid_d   = 1'b1;
      bit_cnt_d = bit_valid ? BW'(1) : '0;
    end else begin
      if (valid_q && out_ready) begin
        valid_d = 1'b0;
      end
      if (bit_valid && !complete) begin
        bit_cnt_d = bit_cnt_q + BW'(1);
      end
    end
    if (bit_valid && (xfer || !complete)) begin
      sh_d = {sh_q[WIDTH-2:0], bit_out};
    end
    if (fail_d) begin
      valid_d = 1'b0;
    end
  end

  // All datapath state.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      div_cnt_q <= '0;
      rc_cnt_q  <= '0;
      prev_q    <= 1'b0;
      fail_q    <= 1'b0;
      sh_q      <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      rc_cnt_q  <= rc_cnt_d;
      prev_q    <= prev_d;
      fail_q    <= fail_d;
      sh_q      <= sh_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign health_fail = fail_q;

endmodule
